// File: rtl/watch_set_cu.sv
// watch_set_cu: set-mode control FSM for a watch (field select, inc/dec pulses, blink).
// Define SET_TIMEOUT_EN to add an idle counter that auto-exits set mode.
module watch_set_cu #(
  parameter int BLINK_HALF  = 25_000_000,
  parameter int TIMEOUT_CYC = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_mode,
  input  logic       i_next,
  input  logic       i_up,
  input  logic       i_down,
  output logic       o_set,
  output logic [1:0] o_sel,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_blank
);
  // Encoding chosen so the state value doubles as the o_sel code.
  typedef enum logic [1:0] {RUN = 2'd0, SET_SEC = 2'd1, SET_MIN = 2'd2, SET_HOUR = 2'd3} state_t;
  localparam int BW = $clog2(BLINK_HALF + 1);
  state_t state_q, state_d;
  logic inc_q, inc_d, dec_q, dec_d, phase_q, phase_d;
  logic [BW-1:0] blink_q, blink_d;
  logic tout, mode, nxt, clr, wrap;
`ifdef SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_q, idle_d;
  assign tout = (state_q != RUN) && (idle_q == TW'(TIMEOUT_CYC - 1));
  always_comb begin
    idle_d = (state_d == RUN || (i_en && (i_mode || i_next || i_up || i_down))) ? '0 : idle_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign tout = (TIMEOUT_CYC < 0);
`endif
  always_comb begin
    mode    = i_en & (i_mode | tout);
    nxt     = i_en & i_next & ~mode & (state_q != RUN);
    inc_d   = i_en & i_up & ~i_down & ~mode & ~i_next & (state_q != RUN);
    dec_d   = i_en & i_down & ~i_up & ~mode & ~i_next & (state_q != RUN);
    state_d = !i_en ? RUN :
              mode  ? (state_q == RUN ? SET_HOUR : RUN) :
              nxt   ? (state_q == SET_HOUR ? SET_MIN : state_q == SET_MIN ? SET_SEC : SET_HOUR) :
              state_q;
    // Restart the blink phase on any visible change so the field shows at once.
    clr     = (state_d == RUN) | (state_d != state_q) | inc_d | dec_d;
    wrap    = (blink_q == BW'(BLINK_HALF - 1));
    blink_d = (clr || wrap) ? '0 : blink_q + 1'b1;
    phase_d = clr ? 1'b0 : phase_q ^ wrap;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      phase_q <= 1'b0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end
  assign o_set   = (state_q != RUN);
  assign o_sel   = state_q;
  assign o_inc   = inc_q;
  assign o_dec   = dec_q;
  assign o_blank = phase_q;
endmodule

// File: tb/tb_watch_set_cu.sv
// tb_watch_set_cu: scoreboard bench for watch_set_cu (BLINK_HALF=4, TIMEOUT_CYC=20).
module tb_watch_set_cu;
  logic clk = 1'b0, reset = 1'b1, i_en = 1'b0;
  logic i_mode = 1'b0, i_next = 1'b0, i_up = 1'b0, i_down = 1'b0;
  logic o_set, o_inc, o_dec, o_blank;
  logic [1:0] o_sel;
  int errors = 0, checks = 0;
  typedef struct {string tag; logic [5:0] v;} exp_t;
  exp_t q[$];

  watch_set_cu #(.BLINK_HALF(4), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .i_en(i_en), .i_mode(i_mode), .i_next(i_next),
    .i_up(i_up), .i_down(i_down), .o_set(o_set), .o_sel(o_sel), .o_inc(o_inc),
    .o_dec(o_dec), .o_blank(o_blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {set,sel,inc,dec,blank}=%b want %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ex(input logic s, input logic [1:0] sel, input logic inc,
                                    input logic dec, input logic blk);
    return {s, sel, inc, dec, blk};
  endfunction

  function automatic logic ph(input int k);
    return ((k / 4) % 2) == 1;
  endfunction

  // b = {mode, next, up, down}; expectation is for the cycle after the edge that samples it.
  task automatic step(input logic en, input logic [3:0] b, input logic [5:0] e, input string tag);
    exp_t x;
    @(negedge clk);
    i_en = en;
    {i_mode, i_next, i_up, i_down} = b;
    x.tag = tag;
    x.v = e;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk(x.tag, {o_set, o_sel, o_inc, o_dec, o_blank}, x.v);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {o_set, o_sel, o_inc, o_dec, o_blank}, 6'b0);
    reset = 1'b0;
    // entry and field cycling
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "enter_hour");
    step(1, 4'b0100, ex(1, 2, 0, 0, 0), "next_min");
    step(1, 4'b0100, ex(1, 1, 0, 0, 0), "next_sec");
    step(1, 4'b0100, ex(1, 3, 0, 0, 0), "next_hour");
    step(1, 4'b1000, ex(0, 0, 0, 0, 0), "exit_run");
    step(1, 4'b0100, ex(0, 0, 0, 0, 0), "next_in_run");
    // inc/dec pulses
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "enter2");
    step(1, 4'b0100, ex(1, 2, 0, 0, 0), "to_min");
    step(1, 4'b0010, ex(1, 2, 1, 0, 0), "inc_pulse");
    step(1, 4'b0000, ex(1, 2, 0, 0, 0), "inc_single");
    step(1, 4'b0011, ex(1, 2, 0, 0, 0), "up_down_none");
    step(1, 4'b0001, ex(1, 2, 0, 1, 0), "dec_pulse");
    step(1, 4'b1000, ex(0, 0, 0, 0, 0), "exit2");
    step(1, 4'b0010, ex(0, 0, 0, 0, 0), "up_in_run");
    step(1, 4'b0001, ex(0, 0, 0, 0, 0), "down_in_run");
    // same-cycle priority
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "enter3");
    step(1, 4'b1110, ex(0, 0, 0, 0, 0), "prio_mode");
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "enter4");
    step(1, 4'b0110, ex(1, 2, 0, 0, 0), "prio_next");
    step(1, 4'b1000, ex(0, 0, 0, 0, 0), "exit4");
    // blink timing in SET_SEC
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "enter5");
    step(1, 4'b0100, ex(1, 2, 0, 0, 0), "b_min");
    step(1, 4'b0100, ex(1, 1, 0, 0, 0), "b_sec");
    for (int k = 1; k <= 5; k++) step(1, 4'b0000, ex(1, 1, 0, 0, ph(k)), "blink_idle");
    step(1, 4'b0001, ex(1, 1, 0, 1, 0), "blink_dec");
    for (int j = 1; j <= 8; j++) step(1, 4'b0000, ex(1, 1, 0, 0, ph(j)), "blink_restart");
    // enable drop
    step(0, 4'b0010, ex(0, 0, 0, 0, 0), "en_drop");
    step(0, 4'b1000, ex(0, 0, 0, 0, 0), "en0_mode_ignored");
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "enter6");
    step(1, 4'b0100, ex(1, 2, 0, 0, 0), "r_min");
    // asynchronous reset mid-set
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {o_set, o_sel, o_inc, o_dec, o_blank}, 6'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 4'b0000, ex(0, 0, 0, 0, 0), "post_reset_run");
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "post_reset_hour");
`ifdef SET_TIMEOUT_EN
    for (int k = 1; k <= 19; k++) step(1, 4'b0000, ex(1, 3, 0, 0, ph(k)), "to_idle");
    step(1, 4'b0000, ex(0, 0, 0, 0, 0), "timeout_exit");
    step(1, 4'b1000, ex(1, 3, 0, 0, 0), "enter_to2");
    for (int k = 1; k <= 14; k++) step(1, 4'b0000, ex(1, 3, 0, 0, ph(k)), "to2_idle");
    step(1, 4'b0010, ex(1, 3, 1, 0, 0), "to2_pulse");
    for (int j = 1; j <= 19; j++) step(1, 4'b0000, ex(1, 3, 0, 0, ph(j)), "to2_restart");
    step(1, 4'b0000, ex(0, 0, 0, 0, 0), "timeout_exit2");
`else
    for (int k = 1; k <= 100; k++) step(1, 4'b0000, ex(1, 3, 0, 0, ph(k)), "no_timeout");
    step(1, 4'b1000, ex(0, 0, 0, 0, 0), "final_exit");
`endif
    step(1, 4'b0000, ex(0, 0, 0, 0, 0), "final_idle");
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) chk("scoreboard_drain", 6'(q.size()), 6'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/watch_set_cu.md
WATCH_SET_CU -- requirements
Module: watch_set_cu

Interface
REQ-001 Parameter BLINK_HALF, default 25_000_000, clk cycles per blink half-period (4 Hz phase toggle at 100 MHz, 2 Hz blink).
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000_000, idle clk cycles before auto-exit from set mode (10 s at 100 MHz).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 i_en  input  1  level; 1 = watch mode selected, set-control enabled.
REQ-006 i_mode  input  1  single-cycle pulse (debounced, edge-detected); enter/exit set mode.
REQ-007 i_next  input  1  single-cycle pulse; advance the selected field.
REQ-008 i_up  input  1  single-cycle pulse; increment the selected field.
REQ-009 i_down  input  1  single-cycle pulse; decrement the selected field.
REQ-010 o_set  output  1  registered; 1 while in any SET state, freezes the time-keeping datapath.
REQ-011 o_sel  output  2  registered; 0 none, 1 sec, 2 min, 3 hour.
REQ-012 o_inc  output  1  registered single-cycle pulse; datapath adds 1 to the selected field.
REQ-013 o_dec  output  1  registered single-cycle pulse; datapath subtracts 1 from the selected field.
REQ-014 o_blank  output  1  registered; 1 = display blanks the selected field for the current blink phase.

Function
REQ-015 FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC; o_sel = 0/3/2/1 respectively, and o_set = (state != RUN).
REQ-016 RUN + i_mode -> SET_HOUR.
REQ-017 Any SET state + i_mode -> RUN.
REQ-018 i_next cycles SET_HOUR -> SET_MIN -> SET_SEC -> SET_HOUR; i_next in RUN is ignored.
REQ-019 Same-cycle priority: i_mode > i_next > i_up/i_down; a lower-priority input in the same cycle as a higher one is discarded.
REQ-020 In a SET state with no i_mode/i_next, i_up alone gives o_inc = 1 on the next cycle only; i_down alone gives o_dec = 1 on the next cycle only.
REQ-021 i_up and i_down together produce no pulse.
REQ-022 o_inc and o_dec are never both 1 and are never asserted in RUN.
REQ-023 Field wrap-around (hour 23->0, min/sec 59->0, and the reverse) belongs to the datapath; this block issues only pulses.
REQ-024 i_en = 0 forces next state RUN, suppresses o_inc/o_dec and clears blink and timeout counters; buttons are ignored while i_en = 0.
REQ-025 Blink counter counts 0..BLINK_HALF-1 in SET states, then wraps and toggles the phase bit.
REQ-026 Blink counter and phase are cleared on entry to any SET state, on every field change, and on every o_inc/o_dec, so the field shows immediately after a change.
REQ-027 o_blank = phase bit in SET states; o_blank = 0 in RUN.
REQ-028 Output latency: every output reflects the inputs sampled on the previous rising edge (1 cycle).

Reset
REQ-029 Reset forces: state RUN, o_set = 0, o_sel = 0, o_inc = 0, o_dec = 0, o_blank = 0, all counters = 0.
REQ-030 Reset asserted mid-set discards the pending field selection; after release the block is in RUN and requires i_mode to re-enter.

Configuration
REQ-031 Macro SET_TIMEOUT_EN, when defined, adds an idle counter that runs in SET states and clears on any i_mode/i_next/i_up/i_down pulse or on leaving SET.
REQ-032 With SET_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYC-1 forces RUN on the next edge, identical to an i_mode exit.
REQ-033 With SET_TIMEOUT_EN undefined, no idle counter exists and SET states are left only by i_mode, i_en = 0 or reset.
REQ-034 Ports are identical in both builds.

Verification (BLINK_HALF = 4, TIMEOUT_CYC = 20)
REQ-035 Mode entry and field cycling: reset, i_en = 1, i_mode pulse -> next cycle o_set = 1, o_sel = 3; then i_next x3 -> o_sel 2, 1, 3; then i_mode -> o_set = 0, o_sel = 0.
REQ-036 Increment/decrement pulses: in SET_MIN, i_up pulse -> o_inc = 1 for exactly 1 cycle and o_blank = 0 that cycle; i_up + i_down in the same cycle -> no pulse; i_up in RUN -> no pulse.
REQ-037 Same-cycle priority: in SET_HOUR, i_mode + i_next + i_up in one cycle -> RUN, o_inc stays 0.
REQ-038 Blink timing: idle in SET_SEC -> o_blank toggles every 4 cycles starting at 0; i_down mid-phase -> o_blank = 0, and the phase restarts.
REQ-039 Enable drop and reset: in SET state drop i_en -> RUN next cycle; assert reset mid-SET -> all outputs 0 asynchronously.
REQ-040 Timeout build: with SET_TIMEOUT_EN, 20 idle cycles in SET -> RUN; a pulse at cycle 15 restarts the count. Without the macro, 100 idle cycles -> still in SET.
